serializer_word_sched: RTL and testbench

SERIALIZER_WORD_SCHED -- requirements
Module: serializer_word_sched

---
 rtl/ser_sched_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 35 +++
 rtl/serializer_word_sched.sv | 137 +++++++++++++
 tb/tb_serializer_word_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ser_sched_pkg.sv
// ============================================================================
//  Module   : ser_sched_pkg
//  Brief    : Shared types and default words for the serializer word scheduler.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ser_sched_pkg;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'b00,
        SRC_REQ0 = 2'b01,
        SRC_REQ1 = 2'b10,
        SRC_SYNC = 2'b11
    } src_e;

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hF00F;
    localparam logic [15:0] DEF_IDLE_WORD = 16'hAAAA;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-way round-robin arbiter; pointer moves only on a grant.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // favour_1 high means requester 1 wins a tie.
    logic favour_1;

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | ~favour_1);
        grant[1] = req[1] & (~req[0] |  favour_1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            favour_1 <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            favour_1 <= grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/serializer_word_sched.sv
// ============================================================================
//  Module   : serializer_word_sched
//  Brief    : Schedules 16-bit words (train SYNC, data, periodic SYNC, idle)
//             into a serializer tree, one word every WORD_CYCLES clocks.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serializer_word_sched
    import ser_sched_pkg::*;
#(
    parameter int unsigned  WORD_CYCLES = 8,
    parameter int unsigned  TRAIN_WORDS = 4,
    parameter int unsigned  SYNC_PERIOD = 64,
    parameter logic [15:0]  SYNC_WORD   = DEF_SYNC_WORD,
    parameter logic [15:0]  IDLE_WORD   = DEF_IDLE_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        VALID0,
    input  logic        VALID1,
    input  logic [15:0] DATA0,
    input  logic [15:0] DATA1,
    output logic        READY0,
    output logic        READY1,
    output logic [15:0] PAR_OUT,
    output logic        LOAD,
    output logic [1:0]  SRC
);

    localparam logic [7:0] SLOT_LAST  = 8'(WORD_CYCLES - 1);
    localparam logic [7:0] TRAIN_LAST = 8'(TRAIN_WORDS - 1);
    localparam logic [9:0] FRAME_LAST = 10'(SYNC_PERIOD - 1);

    state_e      state, state_nxt;
    logic [7:0]  slot;
    logic [7:0]  train_cnt, train_nxt;
    logic [9:0]  frame_cnt, frame_nxt;
    logic [15:0] par_q, par_nxt;
    src_e        src_q, src_nxt;
    logic        load_q;

    logic        boundary;
    logic        sync_slot;
    logic        eligible;
    logic [1:0]  req;
    logic [1:0]  grant;

    always_comb begin
        boundary  = (slot == SLOT_LAST);
        sync_slot = (frame_cnt == FRAME_LAST);
        // Handshakes exist only at RUN data boundaries and never during reset.
        eligible  = ~RST & (state == ST_RUN) & boundary & ~sync_slot & ENABLE;
        req       = {VALID1, VALID0} & {2{eligible}};
    end

    rr_arb2 u_arb (
        .clk     (CLK),
        .rst     (RST),
        .req     (req),
        .advance (|grant),
        .grant   (grant)
    );

    always_comb begin
        state_nxt = state;
        train_nxt = train_cnt;
        frame_nxt = frame_cnt;
        par_nxt   = par_q;
        src_nxt   = src_q;
        if (boundary) begin
            case (state)
                ST_TRAIN: begin
                    par_nxt = SYNC_WORD;
                    src_nxt = SRC_SYNC;
                    if (train_cnt == TRAIN_LAST) begin
                        state_nxt = ST_RUN;
                        train_nxt = 8'd0;
                        frame_nxt = 10'd0;
                    end else begin
                        train_nxt = train_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (sync_slot) begin
                        par_nxt   = SYNC_WORD;
                        src_nxt   = SRC_SYNC;
                        frame_nxt = 10'd0;
                    end else begin
                        frame_nxt = frame_cnt + 10'd1;
                        if (grant[0]) begin
                            par_nxt = DATA0;
                            src_nxt = SRC_REQ0;
                        end else if (grant[1]) begin
                            par_nxt = DATA1;
                            src_nxt = SRC_REQ1;
                        end else begin
                            par_nxt = IDLE_WORD;
                            src_nxt = SRC_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_TRAIN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_TRAIN;
            slot      <= 8'd0;
            train_cnt <= 8'd0;
            frame_cnt <= 10'd0;
            par_q     <= IDLE_WORD;
            src_q     <= SRC_IDLE;
            load_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot      <= boundary ? 8'd0 : slot + 8'd1;
            train_cnt <= train_nxt;
            frame_cnt <= frame_nxt;
            par_q     <= par_nxt;
            src_q     <= src_nxt;
            load_q    <= boundary;
        end
    end

    assign READY0  = grant[0];
    assign READY1  = grant[1];
    assign PAR_OUT = par_q;
    assign SRC     = src_q;
    assign LOAD    = load_q;

endmodule

`default_nettype wire

// File: tb/tb_serializer_word_sched.sv
// ============================================================================
//  Module   : tb_serializer_word_sched
//  Brief    : Directed, table-driven bench for serializer_word_sched (defaults).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serializer_word_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ENABLE;
    logic        VALID0, VALID1;
    logic [15:0] DATA0, DATA1;
    logic        READY0, READY1;
    logic [15:0] PAR_OUT;
    logic        LOAD;
    logic [1:0]  SRC;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic        en;
        logic        v0;
        logic        v1;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] exp_par;
        logic [1:0]  exp_src;
        logic        exp_r0;
        logic        exp_r1;
    } vec_t;

    vec_t vecs[11];

    serializer_word_sched dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENABLE  (ENABLE),
        .VALID0  (VALID0),
        .VALID1  (VALID1),
        .DATA0   (DATA0),
        .DATA1   (DATA1),
        .READY0  (READY0),
        .READY1  (READY1),
        .PAR_OUT (PAR_OUT),
        .LOAD    (LOAD),
        .SRC     (SRC)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic v0, input logic v1,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] p, input logic [1:0] s,
                                input logic r0, input logic r1);
        vec_t v;
        v.en = en; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1;
        v.exp_par = p; v.exp_src = s; v.exp_r0 = r0; v.exp_r1 = r1;
        return v;
    endfunction

    // Starts at slot 0, ends at slot 0 of the next word.
    task automatic run_word(input vec_t v, input string name);
        ENABLE = v.en; VALID0 = v.v0; VALID1 = v.v1; DATA0 = v.d0; DATA1 = v.d1;
        step();
        check({name, " ready0 mid"}, {15'd0, READY0}, 16'd0);
        check({name, " ready1 mid"}, {15'd0, READY1}, 16'd0);
        repeat (6) step();
        check({name, " ready0"}, {15'd0, READY0}, {15'd0, v.exp_r0});
        check({name, " ready1"}, {15'd0, READY1}, {15'd0, v.exp_r1});
        step();
        check({name, " load"}, {15'd0, LOAD}, 16'd1);
        check({name, " par"}, PAR_OUT, v.exp_par);
        check({name, " src"}, {14'd0, SRC}, {14'd0, v.exp_src});
    endtask

    initial begin
        int widx;
        int t_sync0;
        int t_sync1;
        logic is_sync;

        vecs[0]  = mk(1, 1, 0, 16'h1234, 16'h0000, 16'h1234, 2'b01, 1, 0);
        vecs[1]  = mk(1, 1, 0, 16'h1234, 16'h0000, 16'h1234, 2'b01, 1, 0);
        vecs[2]  = mk(1, 1, 1, 16'h1111, 16'h2222, 16'h2222, 2'b10, 0, 1);
        vecs[3]  = mk(1, 1, 1, 16'h1111, 16'h2222, 16'h1111, 2'b01, 1, 0);
        vecs[4]  = mk(1, 1, 1, 16'h1111, 16'h2222, 16'h2222, 2'b10, 0, 1);
        vecs[5]  = mk(1, 0, 1, 16'h0000, 16'hBEEF, 16'hBEEF, 2'b10, 0, 1);
        vecs[6]  = mk(1, 0, 1, 16'h0000, 16'hBEEF, 16'hBEEF, 2'b10, 0, 1);
        vecs[7]  = mk(1, 0, 0, 16'h0000, 16'h0000, 16'hAAAA, 2'b00, 0, 0);
        vecs[8]  = mk(0, 1, 1, 16'h1111, 16'h2222, 16'hAAAA, 2'b00, 0, 0);
        vecs[9]  = mk(1, 1, 1, 16'h1111, 16'h2222, 16'h1111, 2'b01, 1, 0);
        vecs[10] = mk(1, 1, 1, 16'h1111, 16'h2222, 16'h2222, 2'b10, 0, 1);

        // Reset with requests present: no handshake, idle outputs.
        RST = 1'b1; ENABLE = 1'b1; VALID0 = 1'b1; VALID1 = 1'b1;
        DATA0 = 16'h1234; DATA1 = 16'h5678;
        step(); step();
        check("rst ready0", {15'd0, READY0}, 16'd0);
        check("rst ready1", {15'd0, READY1}, 16'd0);
        check("rst par", PAR_OUT, 16'hAAAA);
        check("rst src", {14'd0, SRC}, 16'd0);
        check("rst load", {15'd0, LOAD}, 16'd0);

        // Training: four SYNC loads at cycles 8..32, then idle at 40.
        RST = 1'b0; VALID0 = 1'b0; VALID1 = 1'b0;
        cyc = 0;
        check("c0 load", {15'd0, LOAD}, 16'd0);
        for (int c = 1; c <= 40; c++) begin
            step();
            check("train load", {15'd0, LOAD}, {15'd0, (c % 8) == 0});
            check("train ready0", {15'd0, READY0}, 16'd0);
            if ((c % 8) == 0) begin
                check("train par", PAR_OUT, (c <= 32) ? 16'hF00F : 16'hAAAA);
                check("train src", {14'd0, SRC}, (c <= 32) ? 16'd3 : 16'd0);
            end
        end

        for (int i = 0; i < 11; i++) run_word(vecs[i], $sformatf("vec%0d", i));
        widx = 12;

        // ENABLE drops at slot 3: current word kept, next boundary idle.
        ENABLE = 1'b1; VALID0 = 1'b1; VALID1 = 1'b0; DATA0 = 16'h5555;
        repeat (3) step();
        ENABLE = 1'b0;
        repeat (4) step();
        check("en-drop par held", PAR_OUT, 16'h2222);
        check("en-drop load", {15'd0, LOAD}, 16'd0);
        check("en-drop ready0", {15'd0, READY0}, 16'd0);
        step();
        check("en-drop next par", PAR_OUT, 16'hAAAA);
        check("en-drop next src", {14'd0, SRC}, 16'd0);
        repeat (7) step();
        check("en-off ready0", {15'd0, READY0}, 16'd0);
        step();
        check("en-off par", PAR_OUT, 16'hAAAA);
        repeat (2) step();
        ENABLE = 1'b1;
        repeat (5) step();
        check("en-back ready0", {15'd0, READY0}, 16'd1);
        step();
        check("en-back par", PAR_OUT, 16'h5555);
        check("en-back src", {14'd0, SRC}, 16'd1);
        widx = 15;

        // Continuous data: SYNC at frame positions 63 and 127, 512 cycles apart.
        DATA0 = 16'h1234;
        t_sync0 = -1;
        t_sync1 = -1;
        for (int w = widx; w < 128; w++) begin
            is_sync = ((w % 64) == 63);
            repeat (7) step();
            check("frame ready0", {15'd0, READY0}, {15'd0, ~is_sync});
            check("frame ready1", {15'd0, READY1}, 16'd0);
            step();
            check("frame par", PAR_OUT, is_sync ? 16'hF00F : 16'h1234);
            check("frame src", {14'd0, SRC}, is_sync ? 16'd3 : 16'd1);
            if (is_sync && t_sync0 < 0) t_sync0 = cyc;
            else if (is_sync) t_sync1 = cyc;
        end
        check("sync spacing", 16'(t_sync1 - t_sync0), 16'd512);

        // One-cycle reset at slot 5 mid-frame.
        repeat (5) step();
        RST = 1'b1;
        check("rst-pulse ready0", {15'd0, READY0}, 16'd0);
        step();
        RST = 1'b0;
        check("rst-pulse par", PAR_OUT, 16'hAAAA);
        check("rst-pulse load", {15'd0, LOAD}, 16'd0);
        check("rst-pulse src", {14'd0, SRC}, 16'd0);
        check("rst-pulse ready0 after", {15'd0, READY0}, 16'd0);
        VALID0 = 1'b1; VALID1 = 1'b1; DATA0 = 16'h1111; DATA1 = 16'h2222;
        for (int c = 1; c <= 32; c++) begin
            step();
            check("retrain ready0", {15'd0, READY0}, 16'd0);
            check("retrain ready1", {15'd0, READY1}, 16'd0);
            check("retrain load", {15'd0, LOAD}, {15'd0, (c % 8) == 0});
            if ((c % 8) == 0) check("retrain par", PAR_OUT, 16'hF00F);
        end
        run_word(mk(1, 1, 1, 16'h1111, 16'h2222, 16'h1111, 2'b01, 1, 0), "post-rst first");
        run_word(mk(1, 1, 1, 16'h1111, 16'h2222, 16'h2222, 2'b10, 0, 1), "post-rst second");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
